bin_a_bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using double-dabble (shift / add-3), one input bit per clock.
- Replaces the wide combinational divide/modulo chain in the frequency-counter display path.
- Sits between the frequency counter and the 7-segment digit multiplexer.
- Adds a start/busy/done handshake, a configurable digit count, and overflow saturation.

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_add3.sv | 9 +
 rtl/bin_a_bcd_seq.sv | 115 +++++++++++
 tb/tb_bin_a_bcd_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and elaboration-time helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam int BCD_W = 4;

    // 64-bit result lets the caller detect constants that overflow 32 bits.
    function automatic longint unsigned pow10(input int d);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < d; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_a_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, with overflow saturation.
// Optional macro BIN2BCD_BLANK_EN adds a leading-zero blanking output.
module bin_a_bcd_seq
    import bcd_pkg::*;
#(
    parameter int N   = 17,
    parameter int DIG = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N-1:0]         bin,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_W*DIG-1:0] bcd,
    output logic                 ovf
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIG-1:0]       blank
`endif
);

    localparam int          SW   = BCD_W * DIG;
    localparam int          CW   = cnt_w(N);
    localparam logic [63:0] MAXV = 64'(pow10(DIG) - 1);

    if (DIG < 1 || DIG > 18 || MAXV > 64'hFFFF_FFFF) begin : g_dig_check
        $error("bin_a_bcd_seq: DIG out of range, 10^DIG-1 must fit in 32 bits");
    end

    state_t         state;
    logic [N-1:0]   binreg;
    logic [SW-1:0]  scratch;
    logic [SW-1:0]  adj;
    logic [SW-1:0]  scratch_sh;
    logic [CW-1:0]  cnt;
    logic           ovf_next;

    for (genvar g = 0; g < DIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (scratch[g*BCD_W +: BCD_W]),
            .q (adj[g*BCD_W +: BCD_W])
        );
    end

    // The top bit of the corrected scratch is dropped; overflow saturation covers it.
    assign scratch_sh = {adj[SW-2:0], binreg[N-1]};

`ifdef BIN2BCD_BLANK_EN
    localparam logic [DIG-1:0] BLANK_RST = ~DIG'(1);

    logic [DIG-1:0] blank_nxt;
    logic           zero_run;

    always_comb begin
        blank_nxt = '0;
        zero_run  = 1'b1;
        for (int i = DIG - 1; i >= 1; i--) begin
            zero_run     = zero_run && (scratch[i*BCD_W +: BCD_W] == 4'd0);
            blank_nxt[i] = zero_run;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            binreg   <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_next <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank    <= BLANK_RST;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        binreg   <= bin;
                        scratch  <= '0;
                        cnt      <= CW'(N);
                        ovf_next <= (64'(bin) > MAXV);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_sh;
                    binreg  <= binreg << 1;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    bcd   <= ovf_next ? {DIG{4'h9}} : scratch;
                    ovf   <= ovf_next;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef BIN2BCD_BLANK_EN
                    blank <= ovf_next ? '0 : blank_nxt;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_a_bcd_seq.sv
// Directed bench for bin_a_bcd_seq: three instances (N17/DIG6, N17/DIG4, N1/DIG1).
module tb_bin_a_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start6, start4, start1;
    logic [16:0] bin6, bin4;
    logic [0:0]  bin1;
    logic        busy6, busy4, busy1;
    logic        done6, done4, done1;
    logic [23:0] bcd6;
    logic [15:0] bcd4;
    logic [3:0]  bcd1;
    logic        ovf6, ovf4, ovf1;
`ifdef BIN2BCD_BLANK_EN
    logic [5:0]  blank6;
    logic [3:0]  blank4;
    logic [0:0]  blank1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin_a_bcd_seq #(.N(17), .DIG(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .bin(bin6),
        .busy(busy6), .done(done6), .bcd(bcd6), .ovf(ovf6)
`ifdef BIN2BCD_BLANK_EN
        , .blank(blank6)
`endif
    );

    bin_a_bcd_seq #(.N(17), .DIG(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .bin(bin4),
        .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4)
`ifdef BIN2BCD_BLANK_EN
        , .blank(blank4)
`endif
    );

    bin_a_bcd_seq #(.N(1), .DIG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1)
`ifdef BIN2BCD_BLANK_EN
        , .blank(blank1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts a conversion on instance d and returns edges to done, counting the accepting edge.
    task automatic go(input int d, input logic [16:0] v, output int lat, output int bsy);
        logic dn, bz;
        lat = 0;
        bsy = 0;
        case (d)
            0: begin bin6 = v; start6 = 1'b1; end
            1: begin bin4 = v; start4 = 1'b1; end
            default: begin bin1 = v[0:0]; start1 = 1'b1; end
        endcase
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk);
            #1;
            start6 = 1'b0;
            start4 = 1'b0;
            start1 = 1'b0;
            dn = (d == 0) ? done6 : (d == 1) ? done4 : done1;
            bz = (d == 0) ? busy6 : (d == 1) ? busy4 : busy1;
            lat = e;
            if (bz) bsy++;
            if (dn) break;
        end
    endtask

    int lat, bsy, d1, d2, nd;
    logic [23:0] first_bcd, second_bcd;

    initial begin
        rst_n  = 1'b0;
        start6 = 1'b0; start4 = 1'b0; start1 = 1'b0;
        bin6 = '0; bin4 = '0; bin1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy6, 0);
        chk("rst_done", done6, 0);
        chk("rst_bcd", bcd6, 0);
        chk("rst_ovf", ovf6, 0);
`ifdef BIN2BCD_BLANK_EN
        chk("rst_blank6", blank6, 6'b111110);
        chk("rst_blank1", blank1, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        go(0, 17'd0, lat, bsy);
        chk("zero_lat", lat, 19);
        chk("zero_busy_cycles", bsy, 18);
        chk("zero_bcd", bcd6, 24'h000000);
        chk("zero_ovf", ovf6, 0);
`ifdef BIN2BCD_BLANK_EN
        chk("zero_blank", blank6, 6'b111110);
`endif
        @(posedge clk);
        #1;
        chk("done_one_cycle", done6, 0);
        chk("busy_after_done", busy6, 0);

        go(0, 17'd131071, lat, bsy);
        chk("max_bcd", bcd6, 24'h131071);
        chk("max_ovf", ovf6, 0);
`ifdef BIN2BCD_BLANK_EN
        chk("max_blank", blank6, 6'b000000);
`endif
        go(0, 17'd99999, lat, bsy);
        chk("b2b_gap", lat, 19);
        chk("b2b_bcd", bcd6, 24'h099999);
`ifdef BIN2BCD_BLANK_EN
        chk("b2b_blank", blank6, 6'b100000);
`endif

        go(0, 17'd305, lat, bsy);
        chk("v305_bcd", bcd6, 24'h000305);
`ifdef BIN2BCD_BLANK_EN
        chk("v305_blank", blank6, 6'b111000);
`endif

        go(1, 17'd12345, lat, bsy);
        chk("d4_12345_ovf", ovf4, 1);
        chk("d4_12345_bcd", bcd4, 16'h9999);
`ifdef BIN2BCD_BLANK_EN
        chk("d4_12345_blank", blank4, 4'b0000);
`endif
        go(1, 17'd9999, lat, bsy);
        chk("d4_9999_ovf", ovf4, 0);
        chk("d4_9999_bcd", bcd4, 16'h9999);
        go(1, 17'd10000, lat, bsy);
        chk("d4_10000_ovf", ovf4, 1);
        chk("d4_10000_bcd", bcd4, 16'h9999);
        go(1, 17'd1234, lat, bsy);
        chk("d4_1234_ovf", ovf4, 0);
        chk("d4_1234_bcd", bcd4, 16'h1234);

        go(2, 17'd1, lat, bsy);
        chk("n1_lat", lat, 3);
        chk("n1_bcd", bcd1, 4'h1);
        chk("n1_ovf", ovf1, 0);
`ifdef BIN2BCD_BLANK_EN
        chk("n1_blank", blank1, 0);
`endif

        // start held high across two conversions; bin changes while busy
        bin6 = 17'd4660;
        start6 = 1'b1;
        d1 = 0; d2 = 0; nd = 0;
        first_bcd = '0; second_bcd = '0;
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk);
            #1;
            if (e == 5) bin6 = 17'd7;
            if (done6) begin
                nd++;
                if (d1 == 0) begin
                    d1 = e;
                    first_bcd = bcd6;
                end else if (d2 == 0) begin
                    d2 = e;
                    second_bcd = bcd6;
                    start6 = 1'b0;
                end
            end
        end
        start6 = 1'b0;
        chk("held_first_edge", d1, 19);
        chk("held_second_edge", d2, 38);
        chk("held_done_count", nd, 2);
        chk("held_first_bcd", first_bcd, 24'h004660);
        chk("held_second_bcd", second_bcd, 24'h000007);

        // reset lands on edge k+5 of a conversion
        bin6 = 17'd123456;
        start6 = 1'b1;
        @(posedge clk);
        #1;
        start6 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy6, 0);
        chk("midrst_bcd", bcd6, 0);
        chk("midrst_ovf", ovf6, 0);
        rst_n = 1'b1;
        nd = 0;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk);
            #1;
            if (done6) nd++;
        end
        chk("midrst_no_done", nd, 0);
        go(0, 17'd42, lat, bsy);
        chk("after_rst_lat", lat, 19);
        chk("after_rst_bcd", bcd6, 24'h000042);
`ifdef BIN2BCD_BLANK_EN
        chk("after_rst_blank", blank6, 6'b111100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
